w10_weight_loader: RTL and testbench
====================================

// Module: w10_weight_loader
// PURPOSE
//  Write-side counterpart of the W10 read-address counter. Accepts a stream of
//  hidden-to-output (W10) weights over a valid/ready handshake after a start
//  command. Generates sequential write addresses 0..DEPTH-1 and drives the W10
//  weight RAM write port. Flags done once the full table is loaded, so the
//  classifier datapath can begin reading.
// PARAMETERS
//  DEPTH  256  number of W10 weight words per load (2..2**AW)
//  AW     8    W10 write-address width
//  DW     16   weight word width (signed fixed-point; passed through unmodified)
// PORTS
//  clk          in   1    rising-edge clock
//  W10wa_rst_n  in   1    asynchronous reset, active-low
//  start        in   1    1-cycle load request; honoured only in IDLE
//  abort        in   1    synchronous cancel; returns to IDLE
//  in_valid     in   1    weight word present on in_data
//  in_data      in   DW   weight word
//  in_ready     out  1    loader can accept a word this cycle
//  W10we        out  1    RAM write enable (registered)
//  W10wa        out  AW   RAM write address (registered)
//  W10wd        out  DW   RAM write data (registered)
//  busy         out  1    high while in LOAD
//  done         out  1    1-cycle pulse after the last RAM write issues
// BEHAVIOUR
//  Reset (async, W10wa_rst_n=0): state=IDLE; W10we=0, W10wa=0, W10wd=0,
//   busy=0, done=0, internal word count=0. Outputs stay at reset values while
//   reset is held, and reset overrides everything mid-load.
//  States: IDLE, LOAD, FLUSH, DONE.
//   IDLE : in_ready=0. On start=1 (and abort=0) -> LOAD, word count cleared to 0.
//   LOAD : in_ready=1 (combinational on state). Accept = in_valid & in_ready.
//          On accept: next cycle W10we=1, W10wa=count, W10wd=in_data, count++.
//          Write latency is 1 cycle from accept.
//          Back-to-back accepts produce one write per cycle at consecutive
//          addresses. in_valid=0 inserts gaps; W10we=0 in gap cycles.
//          On the accept with count==DEPTH-1 -> FLUSH; in_ready drops the
//          next cycle, so at most DEPTH words are ever accepted.
//   FLUSH: the cycle carrying the last write (W10we=1, W10wa=DEPTH-1).
//          Unconditionally -> DONE.
//   DONE : done=1 for exactly one cycle, W10we=0. Then -> IDLE.
//  busy = (state==LOAD || state==FLUSH).
//  W10wa holds its last value when W10we=0. It never exceeds DEPTH-1 and
//   never wraps within one load.
//  Count register is $clog2(DEPTH)+1 wide. No arithmetic is applied to data.
//  start outside IDLE is ignored. start and abort together in IDLE: abort
//   wins, stay IDLE.
//  abort in LOAD/FLUSH -> IDLE next cycle with no done pulse. A write already
//   registered for that edge completes. A word accepted in the same cycle as
//   abort is dropped (no write issued).
//  in_data is sampled only on accept; X on in_data otherwise is legal.
// TESTING
//  1 Reset: drive W10wa_rst_n=0 mid-LOAD -> all outputs 0 immediately;
//    state IDLE after release; in_ready=0.
//  2 Full load DEPTH=256, in_valid held 1, data=addr+100 -> 256 writes on
//    consecutive cycles, W10wa 0..255, W10wd 100..355. done is one pulse
//    2 cycles after the last accept. Exactly 256 accepts.
//  3 Gapped stream: in_valid toggling 1,0,0,1... -> W10we only one cycle
//    after each accept; addresses contiguous with no skips or repeats.
//  4 abort asserted after 10 accepts -> exactly 10 writes (addr 0..9), no done;
//    a following start reloads from addr 0.
//  5 start pulsed during LOAD and in DONE -> ignored; start+abort in IDLE ->
//    stays IDLE, in_ready=0.
//  6 DEPTH=2 build: two accepts -> writes at addr 0,1, then done; in_ready=0
//    from the cycle after the 2nd accept.

Source files
------------

// File: rtl/w10_weight_loader.sv
// W10 weight loader: takes a valid/ready stream of hidden-to-output weights and
// writes them to the W10 RAM at addresses 0..DEPTH-1, pulsing done once full.
module w10_weight_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          W10wa_rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          W10we,
  output logic [AW-1:0] W10wa,
  output logic [DW-1:0] W10wd,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_we;
  logic [AW-1:0]   r_wa;
  logic [DW-1:0]   r_wd;
  logic            r_busy;
  logic            r_done;

  logic            w_accept;
  logic            w_last;

  assign in_ready = (r_state == S_LOAD);
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_count == CW'(DEPTH - 1));

  always_ff @(posedge clk or negedge W10wa_rst_n) begin
    if (!W10wa_rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_we    <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: single-cycle pulses default low here and are raised only in the
      // branch that issues them; every state register uses <= so all branches
      // see the pre-edge values.
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort) begin
            // A word handshaken in the abort cycle is deliberately dropped.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_accept) begin
            r_we    <= 1'b1;
            r_wa    <= AW'(r_count);
            r_wd    <= in_data;
            r_count <= r_count + CW'(1);
            if (w_last) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_busy <= 1'b0;
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign W10we = r_we;
  assign W10wa = r_wa;
  assign W10wd = r_wd;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_w10_weight_loader.sv
// Directed bench for w10_weight_loader: a DEPTH=256 instance for the main
// scenarios and a DEPTH=2 instance for the minimum-depth case.
module tb_w10_weight_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, abort, in_valid, in_ready, we, busy, done;
  logic [DW-1:0] in_data, wd;
  logic [AW-1:0] wa;

  logic          s_start, s_abort, s_valid, s_ready, s_we, s_busy, s_done;
  logic [DW-1:0] s_data, s_wd;
  logic [0:0]    s_wa;

  w10_weight_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .W10wa_rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .W10we(we), .W10wa(wa), .W10wd(wd), .busy(busy), .done(done)
  );

  w10_weight_loader #(.DEPTH(2), .AW(1), .DW(DW)) dut2 (
    .clk(clk), .W10wa_rst_n(rst_n), .start(s_start), .abort(s_abort),
    .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
    .W10we(s_we), .W10wa(s_wa), .W10wd(s_wd), .busy(s_busy), .done(s_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle-stamped log of writes, handshakes and done pulses on the main DUT.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_wa[$], q_wd[$], q_wc[$], q_ac[$];
  int acc_cnt = 0, done_cnt = 0, done_cyc = -1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        q_wa.push_back(int'(wa));
        q_wd.push_back(int'(wd));
        q_wc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        q_ac.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Writes since bw must be addresses 0..n-1, data d0+i*dstep, each one cycle after its accept.
  task automatic check_writes(input string tag, input int bw, input int ba, input int n,
                              input int d0, input int dstep);
    int bad = 0;
    check({tag, "_nwr"}, q_wa.size() - bw, n);
    for (int i = 0; i < n; i++) begin
      if (bw + i >= q_wa.size() || ba + i >= q_ac.size()) bad++;
      else if (q_wa[bw+i] != i || q_wd[bw+i] != ((d0 + i * dstep) & 16'hFFFF) ||
               q_wc[bw+i] != q_ac[ba+i] + 1) bad++;
    end
    check({tag, "_seq"}, bad, 0);
  endtask

  int bw, ba, bacc, bdone;

  task automatic snap();
    bw    = q_wa.size();
    ba    = q_ac.size();
    bacc  = acc_cnt;
    bdone = done_cnt;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; in_data = '0;
    s_start = 0; s_abort = 0; s_valid = 0; s_data = '0;

    // 1: reset values, then reset mid-load
    repeat (3) tick();
    check("t1_rst_we", we, 0);
    check("t1_rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("t1_idle_ready", in_ready, 0);
    start_pulse();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(100 + i); tick();
    end
    check("t1_pre_wa", wa, 4);
    #2 rst_n = 1'b0;
    #1;
    check("t1_mid_we", we, 0);
    check("t1_mid_wa", wa, 0);
    check("t1_mid_wd", wd, 0);
    check("t1_mid_busy", busy, 0);
    check("t1_mid_done", done, 0);
    check("t1_mid_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("t1_post_ready", in_ready, 0);
    check("t1_post_busy", busy, 0);

    // 2: full load, continuous valid
    snap();
    start_pulse();
    check("t2_busy", busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = DW'(100 + i); tick();
    end
    check("t2_flush_ready", in_ready, 0);
    repeat (4) tick();
    in_valid = 1'b0;
    check("t2_accepts", acc_cnt - bacc, DEPTH);
    check_writes("t2", bw, ba, DEPTH, 100, 1);
    if (q_wc.size() >= bw + DEPTH) check("t2_span", q_wc[bw+DEPTH-1] - q_wc[bw], DEPTH - 1);
    else check("t2_span", q_wc.size() - bw, DEPTH);
    check("t2_done_cnt", done_cnt - bdone, 1);
    check("t2_done_lat", done_cyc - q_ac[q_ac.size()-1], 2);

    // 3: gapped stream, valid every third cycle, X on idle data
    snap();
    start_pulse();
    for (int i = 0; i < 30; i++) begin
      in_valid = (i % 3 == 0);
      in_data  = in_valid ? DW'(200 + i) : 'x;
      tick();
    end
    in_valid = 1'b0; in_data = '0;
    abort = 1'b1; tick(); abort = 1'b0;
    check("t3_abort_ready", in_ready, 0);
    tick();
    check_writes("t3", bw, ba, 10, 200, 3);
    check("t3_no_done", done_cnt - bdone, 0);

    // 4: abort after 10 accepts, 11th word in abort cycle dropped, then reload
    snap();
    start_pulse();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = DW'(300 + i); tick();
    end
    abort = 1'b1; in_data = DW'(999); tick();
    abort = 1'b0; in_valid = 1'b0;
    check("t4_idle_ready", in_ready, 0);
    check("t4_idle_busy", busy, 0);
    repeat (3) tick();
    check_writes("t4", bw, ba, 10, 300, 1);
    check("t4_no_done", done_cnt - bdone, 0);
    snap();
    start_pulse();
    in_valid = 1'b1; in_data = DW'(16'h55); tick();
    in_valid = 1'b0;
    check("t4_reload_we", we, 1);
    check("t4_reload_wa", wa, 0);
    check("t4_reload_wd", wd, 16'h55);
    abort = 1'b1; tick(); abort = 1'b0;

    // 5: start ignored in LOAD and DONE; start+abort in IDLE stays IDLE
    snap();
    start_pulse();
    for (int i = 0; i < DEPTH; i++) begin
      start    = (i == 3);
      in_valid = 1'b1; in_data = DW'(i); tick();
    end
    start = 1'b0; in_valid = 1'b0;
    check("t5_flush_we", we, 1);
    check("t5_flush_wa", wa, DEPTH - 1);
    check("t5_flush_busy", busy, 1);
    tick();
    check("t5_done", done, 1);
    check("t5_done_we", we, 0);
    check("t5_done_busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_after_done_ready", in_ready, 0);
    check("t5_after_done_pulse", done, 0);
    tick();
    check("t5_after_done_busy", busy, 0);
    check_writes("t5", bw, ba, DEPTH, 0, 1);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("t5_sa_ready", in_ready, 0);
    check("t5_sa_busy", busy, 0);

    // 6: DEPTH=2 instance
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("t6_ready0", s_ready, 1);
    s_valid = 1'b1; s_data = DW'(16'hA0); tick();
    check("t6_w0_we", s_we, 1);
    check("t6_w0_wa", s_wa, 0);
    check("t6_w0_wd", s_wd, 16'hA0);
    check("t6_ready1", s_ready, 1);
    s_data = DW'(16'hA1); tick();
    check("t6_w1_we", s_we, 1);
    check("t6_w1_wa", s_wa, 1);
    check("t6_w1_wd", s_wd, 16'hA1);
    check("t6_flush_ready", s_ready, 0);
    check("t6_flush_busy", s_busy, 1);
    tick();
    check("t6_done", s_done, 1);
    check("t6_done_we", s_we, 0);
    check("t6_done_ready", s_ready, 0);
    tick();
    check("t6_done_end", s_done, 0);
    check("t6_idle_we", s_we, 0);
    s_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
